// File: rtl/disp_ram_arbiter.sv
// Merges N_CH display-field write streams into one display RAM write port.
// Each channel is buffered by a small FIFO; a round-robin arbiter drains one entry per cycle.
module disp_ram_arbiter #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned AW         = 4,
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH-1:0]              ch_we,
  input  logic [N_CH*AW-1:0]           ch_addr,
  input  logic [N_CH*DW-1:0]           ch_data,
  output logic [N_CH-1:0]              ch_drop,
  output logic                         out_we,
  output logic [$clog2(N_CH)+AW-1:0]   out_addr,
  output logic [DW-1:0]                out_data,
  output logic                         idle
);

  localparam int unsigned CW = $clog2(N_CH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = AW + DW;
  localparam logic [PW:0] FullCnt = (PW+1)'(FIFO_DEPTH);

  logic [EW-1:0] mem_q    [N_CH][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [N_CH];
  logic [PW-1:0] rd_ptr_q [N_CH];
  logic [PW:0]   cnt_q    [N_CH];
  logic [CW-1:0] last_q;

  logic [N_CH-1:0] full;
  logic [N_CH-1:0] nonempty;
  logic [N_CH-1:0] push;
  logic [N_CH-1:0] pop;
  logic            gnt_valid;
  logic [CW-1:0]   gnt_idx;
  logic [EW-1:0]   head;

  // Full is judged on the pre-pop count, so a full FIFO never accepts a push-through.
  always_comb begin
    full     = '0;
    nonempty = '0;
    push     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      full[i]     = (cnt_q[i] == FullCnt);
      nonempty[i] = (cnt_q[i] != '0);
      push[i]     = ch_we[i] & ~full[i];
    end
  end

  // Search last+1, last+2, ... so the most recent winner has lowest priority.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      if (!gnt_valid && nonempty[(32'(last_q) + k) % N_CH]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CW'((32'(last_q) + k) % N_CH);
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pop[i] = gnt_valid & (gnt_idx == CW'(i));
    end
    head = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {ch_addr[i*AW +: AW], ch_data[i*DW +: DW]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      last_q   <= CW'(N_CH - 1);
      ch_drop  <= '0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        if (push[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (!push[i] && pop[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
        ch_drop[i] <= ch_we[i] & full[i];
      end
      if (gnt_valid) begin
        out_we   <= 1'b1;
        out_addr <= {gnt_idx, head[EW-1 -: AW]};
        out_data <= head[DW-1:0];
        last_q   <= gnt_idx;
      end else begin
        out_we   <= 1'b0;
      end
    end
  end

  assign idle = ~out_we & ~(|nonempty);

endmodule

// File: tb/tb_disp_ram_arbiter.sv
// Directed bench for disp_ram_arbiter (N_CH=2, AW=4, DW=8, FIFO_DEPTH=4).
module tb_disp_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ch_we;
  logic [7:0]  ch_addr;
  logic [15:0] ch_data;
  logic [1:0]  ch_drop;
  logic        out_we;
  logic [4:0]  out_addr;
  logic [7:0]  out_data;
  logic        idle;

  int n_checks = 0;
  int n_errors = 0;

  logic [12:0] cap_q[$];
  int          drop0_cnt;
  int          drop1_cnt;

  disp_ram_arbiter #(
    .N_CH       (2),
    .AW         (4),
    .DW         (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_we    (ch_we),
    .ch_addr  (ch_addr),
    .ch_data  (ch_data),
    .ch_drop  (ch_drop),
    .out_we   (out_we),
    .out_addr (out_addr),
    .out_data (out_data),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and log any output write or drop pulse seen after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_we === 1'b1) cap_q.push_back({out_addr, out_data});
    if (ch_drop[0] === 1'b1) drop0_cnt++;
    if (ch_drop[1] === 1'b1) drop1_cnt++;
  endtask

  task automatic drive(input logic [1:0] we, input logic [3:0] a0, input logic [7:0] d0,
                       input logic [3:0] a1, input logic [7:0] d1);
    ch_we   = we;
    ch_addr = {a1, a0};
    ch_data = {d1, d0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 4'h0, 8'h00, 4'h0, 8'h00);
    tick();
    rst = 1'b0;
    cap_q.delete();
    drop0_cnt = 0;
    drop1_cnt = 0;
  endtask

  // Both channels push d=0..n-1 with addr=d, then drain; writes logged in cap_q.
  task automatic dual_burst(input int n);
    for (int d = 0; d < n; d++) begin
      drive(2'b11, 4'(d), 8'(d), 4'(d), 8'(d));
      tick();
    end
    drive(2'b00, 4'h0, 8'h00, 4'h0, 8'h00);
    repeat (12) tick();
  endtask

  initial begin
    drive(2'b00, 4'h0, 8'h00, 4'h0, 8'h00);
    do_reset();
    check("rst_out_we", 32'(out_we), 32'h0);
    check("rst_out_addr", 32'(out_addr), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_ch_drop", 32'(ch_drop), 32'h0);
    check("rst_idle", 32'(idle), 32'h1);

    // 1: single write, two-cycle latency
    drive(2'b01, 4'h3, 8'h41, 4'h0, 8'h00);
    tick();
    check("t1_no_early_we", 32'(out_we), 32'h0);
    check("t1_busy", 32'(idle), 32'h0);
    drive(2'b00, 4'h0, 8'h00, 4'h0, 8'h00);
    tick();
    check("t1_we", 32'(out_we), 32'h1);
    check("t1_addr", 32'(out_addr), 32'h03);
    check("t1_data", 32'(out_data), 32'h41);
    check("t1_idle_low", 32'(idle), 32'h0);
    tick();
    check("t1_we_off", 32'(out_we), 32'h0);
    check("t1_idle", 32'(idle), 32'h1);
    check("t1_addr_hold", 32'(out_addr), 32'h03);

    // 2: simultaneous writes on both channels
    do_reset();
    drive(2'b11, 4'h1, 8'h30, 4'h2, 8'h31);
    tick();
    drive(2'b00, 4'h0, 8'h00, 4'h0, 8'h00);
    tick();
    check("t2_we0", 32'(out_we), 32'h1);
    check("t2_addr0", 32'(out_addr), 32'h01);
    check("t2_data0", 32'(out_data), 32'h30);
    tick();
    check("t2_we1", 32'(out_we), 32'h1);
    check("t2_addr1", 32'(out_addr), 32'h12);
    check("t2_data1", 32'(out_data), 32'h31);
    tick();
    check("t2_we_off", 32'(out_we), 32'h0);

    // 3: ch0 streams six entries; a pop every cycle keeps it from filling
    do_reset();
    for (int d = 0; d < 6; d++) begin
      drive(2'b01, 4'(d), 8'(d), 4'h0, 8'h00);
      tick();
    end
    drive(2'b00, 4'h0, 8'h00, 4'h0, 8'h00);
    repeat (10) tick();
    check("t3_count", 32'(cap_q.size()), 32'd6);
    check("t3_drops", 32'(drop0_cnt), 32'd0);
    for (int j = 0; j < 6 && j < cap_q.size(); j++) begin
      check($sformatf("t3_entry%0d", j), 32'(cap_q[j]), 32'({1'b0, 4'(j), 8'(j)}));
    end

    // 4: both channels six entries; ch1 peaks at 4 but is never pushed while full
    do_reset();
    dual_burst(6);
    check("t4_count", 32'(cap_q.size()), 32'd12);
    check("t4_drops", 32'(drop0_cnt + drop1_cnt), 32'd0);
    for (int j = 0; j < 12 && j < cap_q.size(); j++) begin
      check($sformatf("t4_entry%0d", j), 32'(cap_q[j]),
            32'({1'(j % 2), 4'(j / 2), 8'(j / 2)}));
    end

    // 5: seventh push on ch1 meets a full FIFO while it is also being popped
    do_reset();
    for (int d = 0; d < 7; d++) begin
      drive(2'b11, 4'(d), 8'(d), 4'(d), 8'(d));
      tick();
      if (d == 6) check("t5_drop_pulse", 32'(ch_drop), 32'h2);
    end
    drive(2'b00, 4'h0, 8'h00, 4'h0, 8'h00);
    tick();
    check("t5_drop_clear", 32'(ch_drop), 32'h0);
    repeat (12) tick();
    check("t5_drop1_cnt", 32'(drop1_cnt), 32'd1);
    check("t5_drop0_cnt", 32'(drop0_cnt), 32'd0);
    check("t5_count", 32'(cap_q.size()), 32'd13);
    for (int j = 0; j < 12 && j < cap_q.size(); j++) begin
      check($sformatf("t5_entry%0d", j), 32'(cap_q[j]),
            32'({1'(j % 2), 4'(j / 2), 8'(j / 2)}));
    end
    if (cap_q.size() > 12) check("t5_entry12", 32'(cap_q[12]), 32'({1'b0, 4'd6, 8'd6}));

    // 6: reset with three entries queued per channel
    do_reset();
    for (int d = 0; d < 5; d++) begin
      drive(2'b11, 4'(d), 8'(d), 4'(d), 8'(d));
      tick();
    end
    check("t6_busy_before", 32'(out_we), 32'h1);
    rst = 1'b1;
    drive(2'b00, 4'h0, 8'h00, 4'h0, 8'h00);
    tick();
    check("t6_we_at_rst", 32'(out_we), 32'h0);
    check("t6_addr_at_rst", 32'(out_addr), 32'h0);
    check("t6_idle_at_rst", 32'(idle), 32'h1);
    rst = 1'b0;
    cap_q.delete();
    repeat (8) tick();
    check("t6_no_stale", 32'(cap_q.size()), 32'd0);
    check("t6_idle_after", 32'(idle), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
